// File: rtl/apb_pkg.sv
// Shared APB requester definitions: FSM state encoding and default access timeout.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam logic [15:0] APB_TIMEOUT_DEFAULT = 16'd255;

endpackage

// File: rtl/apb_requester.sv
// APB requester: turns one core-side request into one APB transfer and returns
// the completer's answer (or a timeout error) on a valid/ready response channel.
module apb_requester
    import apb_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = APB_TIMEOUT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    input  logic [2:0]  req_prot,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] out_paddr,
    output logic        out_psel,
    output logic        out_penable,
    output logic [2:0]  out_pprot,
    output logic        out_pwrite,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    input  logic        out_pready,
    input  logic [31:0] out_prdata,
    input  logic        out_pslverr
);

    apb_state_e  state_reg, state_next;
    logic [15:0] wait_cnt_reg, wait_cnt_next;
    logic [31:0] addr_reg, wdata_reg, rdata_reg, rdata_next;
    logic [3:0]  strb_reg;
    logic [2:0]  prot_reg;
    logic        write_reg, err_reg, err_next;
    logic        accept, capture;

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        rdata_next    = rdata_reg;
        err_next      = err_reg;
        accept        = 1'b0;
        capture       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    accept        = 1'b1;
                    wait_cnt_next = 16'd0;
                    state_next    = SETUP;
                end
            end
            SETUP: state_next = ACCESS;
            ACCESS: begin
                if (out_pready) begin
                    capture    = 1'b1;
                    rdata_next = write_reg ? 32'h0 : out_prdata;
                    err_next   = out_pslverr;
                    state_next = RESP;
                end else if ((TIMEOUT != 16'd0) && (wait_cnt_reg == TIMEOUT)) begin
                    // Completer never answered: report an error with zero data.
                    capture    = 1'b1;
                    rdata_next = 32'h0;
                    err_next   = 1'b1;
                    state_next = RESP;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 16'd1;
                end
            end
            RESP: begin
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= 16'd0;
            addr_reg     <= 32'h0;
            wdata_reg    <= 32'h0;
            strb_reg     <= 4'h0;
            prot_reg     <= 3'h0;
            write_reg    <= 1'b0;
            rdata_reg    <= 32'h0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (accept) begin
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
                strb_reg  <= req_write ? req_wstrb : 4'h0;
                prot_reg  <= req_prot;
                write_reg <= req_write;
            end
            if (capture) begin
                rdata_reg <= rdata_next;
                err_reg   <= err_next;
            end
        end
    end

    assign req_ready   = (state_reg == IDLE);
    assign resp_valid  = (state_reg == RESP);
    assign resp_rdata  = rdata_reg;
    assign resp_err    = err_reg;
    assign out_psel    = (state_reg == SETUP) || (state_reg == ACCESS);
    assign out_penable = (state_reg == ACCESS);
    assign out_paddr   = addr_reg;
    assign out_pwdata  = wdata_reg;
    assign out_pstrb   = strb_reg;
    assign out_pprot   = prot_reg;
    assign out_pwrite  = write_reg;

endmodule

// File: tb/tb_apb_requester.sv
// Randomized bench for apb_requester: a transaction-level model predicts the
// APB phases and response of each request, including timeout aborts and reset.
module tb_apb_requester;

    localparam logic [15:0] TO = 16'd4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic [2:0]  req_prot = '0;
    logic        resp_valid, resp_ready = 1'b0, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] out_paddr, out_pwdata, out_prdata = '0;
    logic        out_psel, out_penable, out_pwrite, out_pready = 1'b0, out_pslverr = 1'b0;
    logic [2:0]  out_pprot;
    logic [3:0]  out_pstrb;

    int n_checks = 0;
    int n_pass   = 0;

    apb_requester #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_prot(req_prot),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable),
        .out_pprot(out_pprot), .out_pwrite(out_pwrite), .out_pwdata(out_pwdata),
        .out_pstrb(out_pstrb), .out_pready(out_pready), .out_prdata(out_prdata),
        .out_pslverr(out_pslverr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Present a request in IDLE and wait for its acceptance edge.
    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input logic [3:0] st, input logic [2:0] pr, input bit hold);
        req_addr  = a;  req_write = w;  req_wdata = wd;
        req_wstrb = st; req_prot  = pr; req_valid = 1'b1;
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        @(posedge clock); #1;
        if (!hold) req_valid = 1'b0;
    endtask

    // Runs from the SETUP cycle to the response handshake. The completer stalls
    // for 'waits' ACCESS cycles; more than TO stalled cycles means an abort.
    task automatic service(input logic [31:0] a, input logic w, input logic [31:0] wd,
                           input logic [3:0] st, input logic [2:0] pr, input int waits,
                           input logic serr, input logic [31:0] rd, input int rdelay);
        bit          abort;
        int          n_acc;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [3:0]  exp_strb;
        abort    = (TO != 0) && (waits > int'(TO));
        n_acc    = abort ? int'(TO) + 1 : waits + 1;
        exp_rd   = (abort || w) ? 32'h0 : rd;
        exp_err  = abort ? 1'b1 : serr;
        exp_strb = w ? st : 4'h0;

        chk("setup_psel", 32'(out_psel), 32'd1);
        chk("setup_penable", 32'(out_penable), 32'd0);
        chk("setup_paddr", out_paddr, a);
        chk("setup_pwrite", 32'(out_pwrite), 32'(w));
        chk("setup_pwdata", out_pwdata, wd);
        chk("setup_pstrb", 32'(out_pstrb), 32'(exp_strb));
        chk("setup_pprot", 32'(out_pprot), 32'(pr));
        chk("setup_req_ready", 32'(req_ready), 32'd0);
        // Completer inputs outside ACCESS must be ignored.
        out_pready = 1'b1; out_prdata = $urandom; out_pslverr = 1'($urandom);
        @(posedge clock); #1;
        for (int k = 0; k < n_acc; k++) begin
            chk("access_psel", 32'(out_psel), 32'd1);
            chk("access_penable", 32'(out_penable), 32'd1);
            chk("access_paddr", out_paddr, a);
            chk("access_pstrb", 32'(out_pstrb), 32'(exp_strb));
            chk("access_pwdata", out_pwdata, wd);
            out_pready  = (k == waits);
            out_prdata  = (k == waits) ? rd : $urandom;
            out_pslverr = (k == waits) ? serr : 1'($urandom);
            @(posedge clock); #1;
        end
        out_pready = 1'($urandom); out_prdata = $urandom; out_pslverr = 1'($urandom);
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_psel", 32'(out_psel), 32'd0);
        chk("resp_penable", 32'(out_penable), 32'd0);
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_err", 32'(resp_err), 32'(exp_err));
        for (int d = 0; d < rdelay; d++) begin
            @(posedge clock); #1;
            chk("stall_resp_valid", 32'(resp_valid), 32'd1);
            chk("stall_resp_rdata", resp_rdata, exp_rd);
            chk("stall_resp_err", 32'(resp_err), 32'(exp_err));
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_psel", 32'(out_psel), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        chk("post_resp_valid", 32'(resp_valid), 32'd0);
        chk("post_req_ready", 32'(req_ready), 32'd1);
        chk("post_psel", 32'(out_psel), 32'd0);
        $display("txn addr=%h write=%0d waits=%0d abort=%0d rdata=%h err=%0d",
                 a, w, waits, abort, exp_rd, exp_err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, wd, rd;
        logic        w, serr;
        logic [3:0]  st;
        logic [2:0]  pr;
        int          waits, rdelay;

        // Reset state
        #3;
        chk("rst_psel", 32'(out_psel), 32'd0);
        chk("rst_penable", 32'(out_penable), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_paddr", out_paddr, 32'h0);
        chk("rst_pstrb", 32'(out_pstrb), 32'd0);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        // Aligned full-strobe write, zero wait states
        issue(32'h1000_0008, 1'b1, 32'h1234_5678, 4'hF, 3'd0, 1'b0);
        service(32'h1000_0008, 1'b1, 32'h1234_5678, 4'hF, 3'd0, 0, 1'b0, 32'hDEAD_BEEF, 0);
        // Read with three stalled ACCESS cycles
        issue(32'h1000_0004, 1'b0, 32'hCAFE_0000, 4'hF, 3'd2, 1'b0);
        service(32'h1000_0004, 1'b0, 32'hCAFE_0000, 4'hF, 3'd2, 3, 1'b0, 32'h0000_A5A5, 0);
        // Write answered with a slave error
        issue(32'h2000_0010, 1'b1, 32'h0BAD_F00D, 4'h3, 3'd1, 1'b0);
        service(32'h2000_0010, 1'b1, 32'h0BAD_F00D, 4'h3, 3'd1, 1, 1'b1, 32'h0, 2);
        // Completer never ready: timeout abort
        issue(32'h3000_0003, 1'b0, 32'h0, 4'h0, 3'd7, 1'b0);
        service(32'h3000_0003, 1'b0, 32'h0, 4'h0, 3'd7, 20, 1'b0, 32'h1111_2222, 0);
        // Response back-pressure with a request already waiting
        issue(32'h4000_0001, 1'b1, 32'h5555_AAAA, 4'h5, 3'd3, 1'b1);
        service(32'h4000_0001, 1'b1, 32'h5555_AAAA, 4'h5, 3'd3, 0, 1'b0, 32'h0, 5);
        chk("b2b_idle_gap_psel", 32'(out_psel), 32'd0);
        @(posedge clock); #1;
        req_valid = 1'b0;
        service(32'h4000_0001, 1'b1, 32'h5555_AAAA, 4'h5, 3'd3, 0, 1'b0, 32'h0, 0);

        // Random transfers, stall counts spanning both sides of the timeout
        for (int i = 0; i < 30; i++) begin
            a = $urandom; wd = $urandom; rd = $urandom;
            w = 1'($urandom); serr = 1'($urandom); st = 4'($urandom); pr = 3'($urandom);
            waits = $urandom_range(0, 7); rdelay = $urandom_range(0, 3);
            issue(a, w, wd, st, pr, 1'b0);
            service(a, w, wd, st, pr, waits, serr, rd, rdelay);
        end

        // Reset in the middle of ACCESS drops the transfer
        issue(32'h5000_0000, 1'b1, 32'h7777_7777, 4'hF, 3'd0, 1'b0);
        out_pready = 1'b0;
        @(posedge clock); #1;
        chk("pre_rst_penable", 32'(out_penable), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_psel", 32'(out_psel), 32'd0);
        chk("async_rst_penable", 32'(out_penable), 32'd0);
        chk("async_rst_paddr", out_paddr, 32'h0);
        chk("async_rst_resp_valid", 32'(resp_valid), 32'd0);
        out_pready = 1'b1; out_prdata = 32'hFFFF_FFFF;
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        chk("rel_req_ready", 32'(req_ready), 32'd1);
        for (int c = 0; c < 4; c++) begin
            chk("rel_resp_valid", 32'(resp_valid), 32'd0);
            chk("rel_psel", 32'(out_psel), 32'd0);
            @(posedge clock); #1;
        end
        $display("reset during ACCESS dropped transfer");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
